// File: rtl/regbank_pkg.sv
// Shared constants and types for the register-bank read/write sequencers.
package regbank_pkg;

    localparam int NREG   = 32;
    localparam int ADDR_W = 5;
    localparam int REG_W  = 32;
    localparam int HALF_W = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_SHOW_LO = 3'd3,
        S_SHOW_HI = 3'd4
    } reader_state_t;

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer for a raw button plus a one-cycle rising-edge pulse.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic step
);

    logic sync0_r;
    logic sync1_r;
    logic prev_r;

    // Synchronizer chain and delayed copy for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync0_r <= 1'b0;
            sync1_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync0_r <= btn;
            sync1_r <= sync0_r;
            prev_r  <= sync1_r;
        end
    end

    assign step = sync1_r & ~prev_r;

endmodule

// File: rtl/regbank_reader.sv
// Button-stepped readout of a register range, shown as 16-bit halves on LEDs.
module regbank_reader
    import regbank_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [HALF_W-1:0] in,
    input  logic              btn,
    input  logic [REG_W-1:0]  rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic [HALF_W-1:0] out,
    output logic              busy,
    output logic              half
);

    logic step_s;

    btn_edge u_btn_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .step  (step_s)
    );

    reader_state_t     state_r;
    reader_state_t     state_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_s;
    logic [ADDR_W-1:0] remain_r;
    logic [ADDR_W-1:0] remain_s;
    logic [REG_W-1:0]  hold_r;
    logic [REG_W-1:0]  hold_s;
    logic [HALF_W-1:0] out_s;
    logic              half_s;

    // Next-state, counter and capture logic
    always_comb begin
        state_s  = state_r;
        addr_s   = addr_r;
        remain_s = remain_r;
        hold_s   = hold_r;
        case (state_r)
            S_IDLE: begin
                if (step_s) begin
                    addr_s   = in[ADDR_W-1:0];
                    remain_s = in[2*ADDR_W-1:ADDR_W];
                    state_s  = S_FETCH;
                end else begin
                    state_s  = S_IDLE;
                end
            end
            S_FETCH: begin
                state_s = S_WAIT;
            end
            S_WAIT: begin
                hold_s  = rd_data;
                state_s = S_SHOW_LO;
            end
            S_SHOW_LO: begin
                if (step_s) begin
                    state_s = S_SHOW_HI;
                end else begin
                    state_s = S_SHOW_LO;
                end
            end
            S_SHOW_HI: begin
                if (step_s) begin
                    if (remain_r == {ADDR_W{1'b0}}) begin
                        state_s = S_IDLE;
                    end else begin
                        // Address counter is exactly ADDR_W bits, so 31 wraps to 0
                        addr_s   = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        remain_s = remain_r - {{(ADDR_W-1){1'b0}}, 1'b1};
                        state_s  = S_FETCH;
                    end
                end else begin
                    state_s = S_SHOW_HI;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // LED value for the upcoming state, so out/half can be registered without lag
    always_comb begin
        out_s  = {HALF_W{1'b0}};
        half_s = 1'b0;
        case (state_s)
            S_SHOW_LO: begin
                out_s  = hold_s[HALF_W-1:0];
                half_s = 1'b0;
            end
            S_SHOW_HI: begin
                out_s  = hold_s[REG_W-1:HALF_W];
                half_s = 1'b1;
            end
            default: begin
                out_s  = {HALF_W{1'b0}};
                half_s = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= S_IDLE;
            addr_r   <= {ADDR_W{1'b0}};
            remain_r <= {ADDR_W{1'b0}};
            hold_r   <= {REG_W{1'b0}};
            out      <= {HALF_W{1'b0}};
            half     <= 1'b0;
            busy     <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= {ADDR_W{1'b0}};
        end else begin
            state_r  <= state_s;
            addr_r   <= addr_s;
            remain_r <= remain_s;
            hold_r   <= hold_s;
            out      <= out_s;
            half     <= half_s;
            busy     <= (state_s != S_IDLE);
            rd_en    <= (state_s == S_FETCH);
            if (state_s == S_FETCH) begin
                rd_addr <= addr_s;
            end
        end
    end

endmodule

// File: tb/tb_regbank_reader.sv
// Randomized self-checking bench for regbank_reader with a behavioural bank and readout model.
module tb_regbank_reader;

    logic        clk;
    logic        reset;
    logic [15:0] sw;
    logic        btn;
    logic [31:0] rd_data;
    logic [4:0]  rd_addr;
    logic        rd_en;
    logic [15:0] led;
    logic        busy;
    logic        half;

    logic [31:0] bank [0:31];
    logic [4:0]  rd_log [$];
    int          n_cmp;
    int          n_err;

    regbank_reader dut (
        .clk     (clk),
        .reset   (reset),
        .in      (sw),
        .btn     (btn),
        .rd_data (rd_data),
        .rd_addr (rd_addr),
        .rd_en   (rd_en),
        .out     (led),
        .busy    (busy),
        .half    (half)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank read port: data appears the cycle after the strobe
    always @(posedge clk) begin
        if (rd_en) rd_data <= bank[rd_addr];
    end

    // Log every read strobe and its address
    always @(negedge clk) begin
        if (rd_en) rd_log.push_back(rd_addr);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic press(input int hi_cycles);
        @(negedge clk) btn = 1'b1;
        repeat (hi_cycles) @(negedge clk);
        btn = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Reference: registers start..start+remain (mod 32), each shown LSB then MSB, then idle
    task automatic run_session(input logic [15:0] inw);
        int start;
        int n;
        int a;
        start = int'(inw[4:0]);
        n     = int'(inw[9:5]) + 1;
        rd_log.delete();
        sw = inw;
        press(2);
        for (int k = 0; k < n; k++) begin
            a  = (start + k) % 32;
            sw = 16'($urandom);
            check_eq("lo_out",  {16'h0, led}, {16'h0, bank[a][15:0]});
            check_eq("lo_half", {31'h0, half}, 32'h0);
            check_eq("lo_busy", {31'h0, busy}, 32'h1);
            press(2);
            check_eq("hi_out",  {16'h0, led}, {16'h0, bank[a][31:16]});
            check_eq("hi_half", {31'h0, half}, 32'h1);
            press(2);
        end
        check_eq("end_busy", {31'h0, busy}, 32'h0);
        check_eq("end_out",  {16'h0, led}, 32'h0);
        check_eq("end_half", {31'h0, half}, 32'h0);
        check_eq("rd_count", rd_log.size(), n);
        for (int k = 0; k < rd_log.size() && k < n; k++) begin
            check_eq("rd_addr_seq", {27'h0, rd_log[k]}, (start + k) % 32);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset   = 1'b0;
        sw      = 16'h0000;
        btn     = 1'b0;
        rd_data = 32'h0;
        for (int i = 0; i < 32; i++) bank[i] = $urandom;
        bank[1] = 32'h0000000A;
        bank[2] = 32'h12345678;
        bank[3] = 32'hDEADBEEF;

        repeat (3) @(negedge clk);
        check_eq("rst_out",   {16'h0, led}, 32'h0);
        check_eq("rst_addr",  {27'h0, rd_addr}, 32'h0);
        check_eq("rst_rd_en", {31'h0, rd_en}, 32'h0);
        check_eq("rst_busy",  {31'h0, busy}, 32'h0);
        check_eq("rst_half",  {31'h0, half}, 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_session(16'h0001);
        run_session(16'h0022);
        run_session(16'h003F);
        run_session(16'h03E0);

        // Latency from button rise, then a long hold must advance only once
        rd_log.delete();
        sw = 16'h0007;
        @(negedge clk) btn = 1'b1;
        @(posedge clk) #1 check_eq("lat_e1", {31'h0, busy}, 32'h0);
        @(posedge clk) #1 check_eq("lat_e2", {31'h0, busy}, 32'h0);
        @(posedge clk) #1 check_eq("lat_e3", {31'h0, busy}, 32'h1);
        repeat (100) @(negedge clk);
        check_eq("hold_out",  {16'h0, led}, {16'h0, bank[7][15:0]});
        check_eq("hold_half", {31'h0, half}, 32'h0);
        check_eq("hold_rds",  rd_log.size(), 1);
        btn = 1'b0;
        repeat (6) @(negedge clk);
        press(2);
        check_eq("hold_hi", {16'h0, led}, {16'h0, bank[7][31:16]});
        press(2);
        check_eq("hold_idle", {31'h0, busy}, 32'h0);

        // A second edge landing in WAIT is dropped
        rd_log.delete();
        sw = 16'h0025;
        press(2);
        press(2);
        check_eq("drop_pre", {16'h0, led}, {16'h0, bank[5][31:16]});
        @(negedge clk) btn = 1'b1;
        @(negedge clk) btn = 1'b0;
        @(negedge clk) btn = 1'b1;
        repeat (100) @(negedge clk);
        check_eq("drop_out",  {16'h0, led}, {16'h0, bank[6][15:0]});
        check_eq("drop_half", {31'h0, half}, 32'h0);
        btn = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("drop_still", {31'h0, half}, 32'h0);
        press(2);
        check_eq("drop_hi", {16'h0, led}, {16'h0, bank[6][31:16]});
        press(2);
        check_eq("drop_idle", {31'h0, busy}, 32'h0);
        check_eq("drop_rds",  rd_log.size(), 2);

        // Randomized sessions over a re-randomized bank
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 32; i++) bank[i] = $urandom;
            run_session(16'($urandom));
        end

        // Reset asserted while showing an MSB half
        sw = 16'h0049;
        press(2);
        press(2);
        check_eq("pre_rst_half", {31'h0, half}, 32'h1);
        @(negedge clk) reset = 1'b0;
        sw = 16'h0000;
        #1;
        check_eq("mid_rst_out",  {16'h0, led}, 32'h0);
        check_eq("mid_rst_busy", {31'h0, busy}, 32'h0);
        check_eq("mid_rst_half", {31'h0, half}, 32'h0);
        check_eq("mid_rst_rden", {31'h0, rd_en}, 32'h0);
        rd_log.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("post_rst_rds",  rd_log.size(), 0);
        check_eq("post_rst_busy", {31'h0, busy}, 32'h0);
        check_eq("post_rst_out",  {16'h0, led}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regbank_reader.md
# regbank_reader

Button-stepped readout sequencer for the FPGA register-bank build. The input sequencer writes registers from switches, and this block is its read-side counterpart. The user enters a start register and a count on the switches, presses the button, and then steps through each 32-bit register as LSB and MSB halves on the 16 LEDs. It drives the register bank's read port and is instantiated beside the write sequencer in the board top level.

## Interface
- `NREG`, 32: number of registers in the bank.
- `ADDR_W`, 5: register address width, equal to log2(NREG).
- `REG_W`, 32: register data width, fixed at two 16-bit halves.
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: reset, asynchronous, active-low. All state clears while it is low.
- `in` in 16: switch inputs. Sampled only on an accepted button edge in IDLE.
- `btn` in 1: raw push-button, asynchronous to `clk`.
- `rd_data` in REG_W: register bank read data, valid on the cycle after `rd_en`.
- `rd_addr` out ADDR_W: register bank read address.
- `rd_en` out 1: one-cycle read strobe.
- `out` out 16: LED data.
- `busy` out 1: high in any state other than IDLE.
- `half` out 1: 0 when `out` shows the LSB half, 1 when it shows the MSB half.

## Operation
- Button path: 2-flop synchronizer followed by a rising-edge detector, producing the one-cycle pulse `step`. Holding `btn` high yields exactly one `step`. No debounce is done here.
- States: IDLE, FETCH, WAIT, SHOW_LO, SHOW_HI.
- IDLE: `out`=0, `busy`=0, `half`=0. On `step`:
  - `addr` <= `in[4:0]`
  - `remain` <= `in[9:5]`, so the number of registers read is `remain`+1, from 1 to 32.
  - `in[15:10]` is ignored.
  - Next state is FETCH.
- FETCH: `rd_en`=1 and `rd_addr`=`addr` for exactly one cycle, then WAIT.
- WAIT: `hold` <= `rd_data`, then SHOW_LO.
- SHOW_LO: `out`=`hold[15:0]`, `half`=0. On `step`, go to SHOW_HI.
- SHOW_HI: `out`=`hold[31:16]`, `half`=1. On `step`:
  - If `remain`==0, go to IDLE.
  - Otherwise `addr` <= `addr`+1 modulo NREG (31 wraps to 0), `remain` <= `remain`-1, and go to FETCH.
- A `step` arriving in FETCH or WAIT is dropped, not queued.
- `rd_addr` holds its last value when `rd_en`=0. The bank must ignore `rd_addr` while `rd_en` is low.

## Timing
- Reset values: `out`=0, `rd_addr`=0, `rd_en`=0, `busy`=0, `half`=0, state=IDLE, `hold`=0, `remain`=0.
- Reset asserted mid-sequence returns the block to IDLE immediately. No read strobe is issued while reset is low.
- Button latency: if `btn` rises before clk edge E1, the state changes on edge E3. `step` is high between E2 and E3.
- Readout latency from an accepted `step` in IDLE or SHOW_HI:
  - FETCH is entered one edge later.
  - WAIT follows on the next edge.
  - SHOW_LO follows on the next edge.
  - `out` shows the new LSB 3 cycles after the accepting edge.
- `out` and `half` are registered, with no combinational path from `rd_data` to `out`.
- `btn` must be low for at least 2 clk cycles between presses to register a new edge.

## Structure
- Shared package `regbank_pkg`:
  - `NREG`, `ADDR_W`, `REG_W` constants.
  - LED half width of 16.
  - `reader_state_t` enum (IDLE, FETCH, WAIT, SHOW_LO, SHOW_HI).
- Sub-module `btn_edge`: 2-flop synchronizer plus rising-edge pulse, same clock and reset. It is reused by the write sequencer.
- Top `regbank_reader` contains the FSM, the `addr`/`remain` counters and the `hold` register.

## Test plan
- Reset mid-SHOW_HI with `in`=0 -> the FSM returns to IDLE. All outputs are 0 and no `rd_en` pulse occurs afterwards.
- Bank preloaded with R1=0x0000000A. Press with `in`=0x0001, so start 1 and count 1 -> one `rd_en` with `rd_addr`=1, `out`=0x000A with `half`=0. Next press -> `out`=0x0000 with `half`=1. Next press -> IDLE with `busy`=0.
- R2=0x12345678, R3=0xDEADBEEF, `in`=0x0022 (start 2, remain 1) -> `out` sequence 0x5678, 0x1234, 0xBEEF, 0xDEAD, then IDLE after the 4th step. Exactly 2 `rd_en` pulses occur.
- Wrap-around: `in`=0x003F (start 31, remain 1) -> `rd_addr` is 31, then 0.
- Full sweep: `in`=0x03E0 (start 0, remain 31) -> 32 `rd_en` pulses with addresses 0..31 and 64 further steps. `busy` drops after the last MSB step.
- Press during WAIT and `btn` held high for 100 cycles -> the extra press is ignored. The held button advances only one half. Measured latency from `btn` rise to state change is 3 edges.
